// File: rtl/clk_div_sched_pkg.sv
// rtl/clk_div_sched_pkg.sv - shared types and defaults for the clock-divider scheduler
package clk_div_sched_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_RUN  = 2'd1,
    CH_PEND = 2'd2
  } ch_state_t;

  typedef struct packed {
    logic                 en;
    logic [CNT_W_DEF-1:0] div;
  } cfg_t;

  // A zero divisor can never produce a period, so it is folded into a stop request.
  function automatic logic req_runs(input logic en, input int unsigned div);
    return en && (div != 0);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// rtl/clk_div_channel.sv - one divide channel: OFF/RUN/PEND state, counter, pending update, output flops
module clk_div_channel
  import clk_div_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             acc_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick_o,
  output logic             clk_o,
  output logic             active_o,
  output logic             pend_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pdiv_q, pdiv_d;
  logic             pen_q, pen_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic             active_q, active_d;
  logic             pend_q, pend_d;
  logic             wrap;
  logic             req_run;

  assign wrap    = (cnt_q == div_q - ONE);
  assign req_run = req_runs(en_i, 32'(div_i));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pen_d   = pen_q;
    pdiv_d  = pdiv_q;
    unique case (state_q)
      CH_OFF: begin
        cnt_d = '0;
        if (acc_i && req_run) begin
          state_d = CH_RUN;
          div_d   = div_i;
        end
      end
      CH_RUN: begin
        cnt_d = wrap ? '0 : cnt_q + ONE;
        // The current period always finishes under the old divisor, even on a wrap edge.
        if (acc_i) begin
          state_d = CH_PEND;
          pen_d   = req_run;
          pdiv_d  = div_i;
        end
      end
      CH_PEND: begin
        cnt_d = wrap ? '0 : cnt_q + ONE;
        if (wrap) begin
          if (pen_q) begin
            state_d = CH_RUN;
            div_d   = pdiv_q;
          end else begin
            state_d = CH_OFF;
            div_d   = '0;
          end
          pen_d  = 1'b0;
          pdiv_d = '0;
        end
      end
      default: begin
        state_d = CH_OFF;
        cnt_d   = '0;
        div_d   = '0;
      end
    endcase
  end

  // Outputs are registered copies of what the next counter value implies.
  always_comb begin
    active_d = (state_d != CH_OFF);
    pend_d   = (state_d == CH_PEND);
    tick_d   = active_d && (cnt_d == div_d - ONE);
    clk_d    = active_d && (cnt_d < (div_d >> 1));
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= CH_OFF;
      cnt_q    <= '0;
      div_q    <= '0;
      pen_q    <= 1'b0;
      pdiv_q   <= '0;
      tick_q   <= 1'b0;
      clk_q    <= 1'b0;
      active_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pen_q    <= pen_d;
      pdiv_q   <= pdiv_d;
      tick_q   <= tick_d;
      clk_q    <= clk_d;
      active_q <= active_d;
      pend_q   <= pend_d;
    end
  end

  assign tick_o   = tick_q;
  assign clk_o    = clk_q;
  assign active_o = active_q;
  assign pend_o   = pend_q;

endmodule

// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - config port decode and per-channel divider array
module clk_div_sched
  import clk_div_sched_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_en,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] ch_tick,
  output logic [NUM_CH-1:0] ch_clk,
  output logic [NUM_CH-1:0] ch_active,
  output logic [NUM_CH-1:0] pend
);

  logic [NUM_CH-1:0] acc;

  // A channel holding an unapplied update stalls further requests to it; unmapped ids are always ready.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pend[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign acc[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

    clk_div_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_in   (clk_in),
      .rst      (rst),
      .acc_i    (acc[g]),
      .en_i     (cfg_en),
      .div_i    (cfg_div),
      .tick_o   (ch_tick[g]),
      .clk_o    (ch_clk[g]),
      .active_o (ch_active[g]),
      .pend_o   (pend[g])
    );
  end

endmodule
